// File: rtl/imm_ext_pipe_if.sv
// Decode-side bundle for the immediate generator: instruction in, extended immediate out.
interface imm_ext_pipe_if #(
    parameter int XLEN      = 32,
    parameter int ERR_CNT_W = 16
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          instr;
    logic [2:0]           imm_src;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      imm_ext;
    logic                 imm_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output flush, in_valid, instr, imm_src, out_ready,
        input  in_ready, out_valid, imm_ext, imm_err, err_cnt
    );

    modport slave (
        input  flush, in_valid, instr, imm_src, out_ready,
        output in_ready, out_valid, imm_ext, imm_err, err_cnt
    );
endinterface

// File: rtl/imm_ext_pipe.sv
// Immediate generator: format select/auto-decode, XLEN extension, 2-entry output buffer
// and a saturating count of accepted illegal-format entries.
module imm_ext_pipe #(
    parameter int XLEN        = 32,
    parameter int AUTO_DECODE = 0,
    parameter int ERR_CNT_W   = 16
) (
    input logic          clk,
    input logic          reset,
    imm_ext_pipe_if.slave bus
);

    localparam logic [2:0] FMT_I   = 3'd0;
    localparam logic [2:0] FMT_S   = 3'd1;
    localparam logic [2:0] FMT_B   = 3'd2;
    localparam logic [2:0] FMT_J   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_Z   = 3'd5;
    localparam logic [2:0] FMT_SH  = 3'd6;
    localparam logic [2:0] FMT_ILL = 3'd7;

    function automatic logic [2:0] shift_or_i(input logic [2:0] f3);
        return (f3 == 3'b001 || f3 == 3'b101) ? FMT_SH : FMT_I;
    endfunction

    function automatic logic [2:0] decode_fmt(input logic [31:0] ins);
        logic [2:0] fmt;
        case (ins[6:0])
            7'b0010011:             fmt = shift_or_i(ins[14:12]);
            7'b0011011:             fmt = (XLEN == 64) ? shift_or_i(ins[14:12]) : FMT_ILL;
            7'b0000011, 7'b1100111: fmt = FMT_I;
            7'b0100011:             fmt = FMT_S;
            7'b1100011:             fmt = FMT_B;
            7'b1101111:             fmt = FMT_J;
            7'b0110111, 7'b0010111: fmt = FMT_U;
            7'b1110011:             fmt = ins[14] ? FMT_Z : FMT_I;
            default:                fmt = FMT_ILL;
        endcase
        return fmt;
    endfunction

    function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [31:0]          ins;
    logic [2:0]           fmt_p0;
    logic [XLEN-1:0]      imm_p0;
    logic                 err_p0;
    logic                 rdy;
    logic                 push;
    logic                 pop;

    logic [1:0]           cnt_p1;
    logic                 vld_p1;
    logic [XLEN-1:0]      hd_imm_p1;
    logic                 hd_err_p1;
    logic [XLEN-1:0]      tl_imm_p1;
    logic                 tl_err_p1;
    logic [ERR_CNT_W-1:0] err_cnt_p1;

    assign ins    = bus.instr;
    assign fmt_p0 = (AUTO_DECODE != 0) ? decode_fmt(ins) : bus.imm_src;

    // p0: extension is done here so entries are stored already at XLEN width
    always_comb begin
        imm_p0 = '0;
        err_p0 = 1'b0;
        case (fmt_p0)
            FMT_I:  imm_p0 = sext32({{20{ins[31]}}, ins[31:20]});
            FMT_S:  imm_p0 = sext32({{20{ins[31]}}, ins[31:25], ins[11:7]});
            FMT_B:  imm_p0 = sext32({{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
            FMT_J:  imm_p0 = sext32({{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
            FMT_U:  imm_p0 = sext32({ins[31:12], 12'b0});
            FMT_Z:  imm_p0 = XLEN'(ins[19:15]);
            FMT_SH: begin
                if (XLEN == 64) begin
                    imm_p0 = XLEN'(ins[25:20]);
                end else begin
                    imm_p0 = XLEN'(ins[24:20]);
                    err_p0 = ins[25];
                end
            end
            default: err_p0 = 1'b1;
        endcase
    end

    assign rdy    = (cnt_p1 != 2'd2) && !reset;
    assign vld_p1 = (cnt_p1 != 2'd0);
    assign push   = bus.in_valid && rdy;
    assign pop    = vld_p1 && bus.out_ready;

    // p1: two-entry buffer; a vacated slot is zeroed so idle outputs read as 0
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p1     <= 2'd0;
            hd_imm_p1  <= '0;
            hd_err_p1  <= 1'b0;
            tl_imm_p1  <= '0;
            tl_err_p1  <= 1'b0;
            err_cnt_p1 <= '0;
        end else begin
            if (push && err_p0 && !bus.flush)
                err_cnt_p1 <= sat_inc(err_cnt_p1);
            if (bus.flush) begin
                cnt_p1    <= 2'd0;
                hd_imm_p1 <= '0;
                hd_err_p1 <= 1'b0;
                tl_imm_p1 <= '0;
                tl_err_p1 <= 1'b0;
            end else begin
                case (cnt_p1)
                    2'd0: begin
                        if (push) begin
                            hd_imm_p1 <= imm_p0;
                            hd_err_p1 <= err_p0;
                            cnt_p1    <= 2'd1;
                        end
                    end
                    2'd1: begin
                        if (push && pop) begin
                            hd_imm_p1 <= imm_p0;
                            hd_err_p1 <= err_p0;
                        end else if (push) begin
                            tl_imm_p1 <= imm_p0;
                            tl_err_p1 <= err_p0;
                            cnt_p1    <= 2'd2;
                        end else if (pop) begin
                            hd_imm_p1 <= '0;
                            hd_err_p1 <= 1'b0;
                            cnt_p1    <= 2'd0;
                        end
                    end
                    default: begin
                        if (pop) begin
                            hd_imm_p1 <= tl_imm_p1;
                            hd_err_p1 <= tl_err_p1;
                            tl_imm_p1 <= '0;
                            tl_err_p1 <= 1'b0;
                            cnt_p1    <= 2'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld_p1;
    assign bus.imm_ext   = hd_imm_p1;
    assign bus.imm_err   = hd_err_p1;
    assign bus.err_cnt   = err_cnt_p1;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: RV32 manual-select and RV64 auto-decode instances against
// a reference extender with a scoreboard queue per instance.
module tb_imm_ext_pipe;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imm_ext_pipe_if #(.XLEN(32), .ERR_CNT_W(16)) if0 ();
    imm_ext_pipe_if #(.XLEN(64), .ERR_CNT_W(2))  if1 ();

    imm_ext_pipe #(.XLEN(32), .AUTO_DECODE(0), .ERR_CNT_W(16)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    imm_ext_pipe #(.XLEN(64), .AUTO_DECODE(1), .ERR_CNT_W(2))  dut1 (.clk(clk), .reset(reset), .bus(if1));

    int n_chk  = 0;
    int n_pass = 0;
    logic [64:0] q0[$];
    logic [64:0] q1[$];
    int ecnt_m[2] = '{0, 0};
    logic [6:0] ops [0:11] = '{7'h13, 7'h1B, 7'h03, 7'h67, 7'h23, 7'h63,
                                7'h6F, 7'h37, 7'h17, 7'h73, 7'h0B, 7'h7F};

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // Reference: {err, imm} built from a sign mask and shifted fields, truncated for RV32
    function automatic logic [64:0] ref_ext(input bit x64, input bit autod,
                                            input logic [31:0] ins, input logic [2:0] src);
        logic [63:0] sg, r;
        logic        e;
        logic [2:0]  f, f3;
        logic [6:0]  op;
        sg = {64{ins[31]}};
        r = 64'd0; e = 1'b0; f = src; op = ins[6:0]; f3 = ins[14:12];
        if (autod) begin
            if (op == 7'h13 || (op == 7'h1B && x64)) f = (f3 == 3'd1 || f3 == 3'd5) ? 3'd6 : 3'd0;
            else if (op == 7'h03 || op == 7'h67) f = 3'd0;
            else if (op == 7'h23) f = 3'd1;
            else if (op == 7'h63) f = 3'd2;
            else if (op == 7'h6F) f = 3'd3;
            else if (op == 7'h37 || op == 7'h17) f = 3'd4;
            else if (op == 7'h73) f = f3[2] ? 3'd5 : 3'd0;
            else f = 3'd7;
        end
        case (f)
            3'd0: r = (sg << 11) | 64'(ins[30:20]);
            3'd1: r = (sg << 11) | (64'(ins[30:25]) << 5) | 64'(ins[11:7]);
            3'd2: r = (sg << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
            3'd3: r = (sg << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
            3'd4: r = (sg << 31) | (64'(ins[30:12]) << 12);
            3'd5: r = 64'(ins[19:15]);
            3'd6: begin
                if (x64) r = 64'(ins[25:20]);
                else begin r = 64'(ins[24:20]); e = ins[25]; end
            end
            default: e = 1'b1;
        endcase
        if (!x64) r = {32'd0, r[31:0]};
        return {e, r};
    endfunction

    task automatic mon(input int d, input bit x64, input bit autod, input int cw,
                       input logic iv, input logic ir, input logic [31:0] ins, input logic [2:0] src,
                       input logic fl, input logic ov, input logic ordy, input logic [63:0] imm,
                       input logic ie, input logic [15:0] ec);
        logic [64:0] q[$];
        logic [64:0] e;
        if (d == 0) q = q0; else q = q1;
        chk($sformatf("d%0d in_ready", d), 65'(ir), 65'((q.size() != 2) && !reset));
        chk($sformatf("d%0d out_valid", d), 65'(ov), 65'(q.size() != 0));
        if (q.size() == 0) chk($sformatf("d%0d idle head", d), {ie, imm}, 65'd0);
        else chk($sformatf("d%0d head", d), {ie, imm}, q[0]);
        chk($sformatf("d%0d err_cnt", d), 65'(ec), 65'(ecnt_m[d]));
        if (reset) begin
            q.delete();
            ecnt_m[d] = 0;
        end else if (fl) begin
            q.delete();
        end else begin
            if (ov && ordy && q.size() != 0) void'(q.pop_front());
            if (iv && ir) begin
                e = ref_ext(x64, autod, ins, src);
                q.push_back(e);
                if (e[64] && ecnt_m[d] < (1 << cw) - 1) ecnt_m[d]++;
            end
        end
        if (d == 0) q0 = q; else q1 = q;
    endtask

    always @(negedge clk) begin
        mon(0, 1'b0, 1'b0, 16, if0.in_valid, if0.in_ready, if0.instr, if0.imm_src, if0.flush,
            if0.out_valid, if0.out_ready, 64'(if0.imm_ext), if0.imm_err, if0.err_cnt);
        mon(1, 1'b1, 1'b1, 2, if1.in_valid, if1.in_ready, if1.instr, if1.imm_src, if1.flush,
            if1.out_valid, if1.out_ready, if1.imm_ext, if1.imm_err, 16'(if1.err_cnt));
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic push0(input logic [31:0] ins, input logic [2:0] src);
        bit acc = 1'b0;
        if0.in_valid = 1'b1; if0.instr = ins; if0.imm_src = src;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk); acc = if0.in_ready; sync();
        end
        if0.in_valid = 1'b0;
        chk("d0 push accepted", 65'(acc), 65'd1);
    endtask

    task automatic push1(input logic [31:0] ins);
        bit acc = 1'b0;
        if1.in_valid = 1'b1; if1.instr = ins; if1.imm_src = 3'd7;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk); acc = if1.in_ready; sync();
        end
        if1.in_valid = 1'b0;
        chk("d1 push accepted", 65'(acc), 65'd1);
    endtask

    task automatic offer0(input logic [31:0] ins, input logic [2:0] src);
        if0.in_valid = 1'b1; if0.instr = ins; if0.imm_src = src;
        sync();
        if0.in_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r32;
        reset = 1'b1;
        if0.flush = 0; if0.in_valid = 0; if0.instr = '0; if0.imm_src = '0; if0.out_ready = 0;
        if1.flush = 0; if1.in_valid = 0; if1.instr = '0; if1.imm_src = '0; if1.out_ready = 0;
        repeat (3) sync();
        @(negedge clk);
        chk("rst in_ready", 65'(if0.in_ready), 65'd0);
        chk("rst out_valid", 65'(if0.out_valid), 65'd0);
        chk("rst imm/err", {if0.imm_err, 33'd0, if0.imm_ext}, 65'd0);
        chk("rst err_cnt", 65'(if0.err_cnt), 65'd0);
        sync();
        reset = 1'b0;
        @(negedge clk);
        chk("post-rst in_ready", 65'(if0.in_ready), 65'd1);
        sync();

        // RV32 manual formats
        if0.out_ready = 1'b1;
        push0(32'hFFF00093, 3'd0);
        @(negedge clk);
        chk("I FFF00093", {if0.imm_err, 32'd0, if0.imm_ext}, 65'h0_FFFFFFFF);
        chk("I out_valid", 65'(if0.out_valid), 65'd1);
        sync();
        push0(32'hFE000EE3, 3'd2);
        @(negedge clk); chk("B FE000EE3", 65'(if0.imm_ext), 65'hFFFFFFFC); sync();
        push0(32'h12345037, 3'd4);
        @(negedge clk); chk("U 12345037", 65'(if0.imm_ext), 65'h12345000); sync();

        // stall: third offer must be refused, then drain in order
        if0.out_ready = 1'b0;
        offer0(32'h7FF00113, 3'd0);
        offer0(32'h00112623, 3'd1);
        if0.in_valid = 1'b1; if0.instr = 32'hFE000EE3; if0.imm_src = 3'd2;
        @(negedge clk); chk("full in_ready", 65'(if0.in_ready), 65'd0); sync();
        if0.out_ready = 1'b1;
        push0(32'hFE000EE3, 3'd2);
        repeat (4) sync();
        @(negedge clk); chk("drained", 65'(if0.out_valid), 65'd0); sync();

        repeat (3) push0(32'h0000_0000, 3'd7);
        @(negedge clk); chk("err_cnt 3", 65'(if0.err_cnt), 65'd3); sync();

        // flush with two entries held, then with one held and a live error push
        if0.out_ready = 1'b0;
        offer0(32'h00100093, 3'd0);
        offer0(32'h00112623, 3'd1);
        if0.flush = 1'b1; if0.in_valid = 1'b1; if0.imm_src = 3'd7;
        sync();
        if0.flush = 1'b0; if0.in_valid = 1'b0;
        @(negedge clk);
        chk("flush2 out_valid", 65'(if0.out_valid), 65'd0);
        chk("flush2 err_cnt", 65'(if0.err_cnt), 65'd3);
        sync();
        offer0(32'h00100093, 3'd0);
        if0.flush = 1'b1; if0.in_valid = 1'b1; if0.imm_src = 3'd7;
        sync();
        if0.flush = 1'b0; if0.in_valid = 1'b0;
        @(negedge clk);
        chk("flush1 out_valid", 65'(if0.out_valid), 65'd0);
        chk("flush1 err_cnt", 65'(if0.err_cnt), 65'd3);
        sync();
        if0.out_ready = 1'b1;

        // RV64 auto-decode
        if1.out_ready = 1'b1;
        push1(32'h800000B7);
        @(negedge clk); chk("d1 lui", {if1.imm_err, if1.imm_ext}, 65'h0_FFFFFFFF80000000); sync();
        push1(32'h03F09093);
        @(negedge clk); chk("d1 slli 63", {if1.imm_err, if1.imm_ext}, 65'd63); sync();
        push1(32'hFFF0009B);
        @(negedge clk); chk("d1 addiw -1", {if1.imm_err, if1.imm_ext}, 65'h0_FFFFFFFFFFFFFFFF); sync();
        repeat (5) push1(32'h0000_0000);
        @(negedge clk); chk("d1 err_cnt sat", 65'(if1.err_cnt), 65'd3); sync();

        // random traffic on both instances
        for (int c = 0; c < 300; c++) begin
            if0.in_valid  = ($urandom_range(3) != 0);
            r32 = $urandom;
            if0.instr     = r32;
            if0.imm_src   = 3'($urandom_range(7));
            if0.out_ready = ($urandom_range(3) != 0);
            if0.flush     = ($urandom_range(31) == 0);
            r32 = $urandom;
            if1.in_valid  = ($urandom_range(3) != 0);
            if1.instr     = {r32[31:7], ops[$urandom_range(11)]};
            if1.out_ready = ($urandom_range(3) != 0);
            if1.flush     = ($urandom_range(31) == 0);
            sync();
        end
        if0.in_valid = 0; if0.flush = 0; if0.out_ready = 1;
        if1.in_valid = 0; if1.flush = 0; if1.out_ready = 1;
        repeat (4) sync();

        // reset mid-stream
        if0.out_ready = 0; if1.out_ready = 0;
        if0.in_valid = 1; if0.instr = 32'h0; if0.imm_src = 3'd7;
        if1.in_valid = 1; if1.instr = 32'h0;
        repeat (2) sync();
        if0.in_valid = 0; if1.in_valid = 0;
        @(negedge clk);
        chk("pre-rst d0 out_valid", 65'(if0.out_valid), 65'd1);
        chk("pre-rst d1 out_valid", 65'(if1.out_valid), 65'd1);
        sync();
        reset = 1'b1;
        sync();
        @(negedge clk);
        chk("mid-rst d0 state", {if0.imm_err, if0.out_valid, if0.in_ready, if0.err_cnt, if0.imm_ext}, 65'd0);
        chk("mid-rst d1 state", {if1.imm_err, if1.imm_ext}, 65'd0);
        chk("mid-rst d1 ctl", {if1.out_valid, if1.in_ready, if1.err_cnt}, 65'd0);
        sync();
        reset = 1'b0;
        @(negedge clk);
        chk("post-rst2 in_ready", {if0.in_ready, if1.in_ready}, 65'd3);
        sync();
        repeat (2) sync();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts a 32-bit instruction and produces the sign- or zero-extended immediate at XLEN width, registered behind a 2-entry valid/ready buffer. Compared with the combinational 4-format extender, it adds U-type, CSR zimm and shift-amount formats, an RV64 width option, an opcode-driven auto-decode mode, illegal-format flagging and a saturating error counter. It sits between fetch/decode and the register-read stage, and can absorb one cycle of downstream stall without bubbling.

## Interface
- XLEN, 32: output immediate width. Legal values are 32 and 64.
- AUTO_DECODE, 0: selects how the format is chosen. 0 means IMM_SRC selects the format. 1 means the format is derived from INSTR[6:0]/[14:12] and IMM_SRC is ignored.
- ERR_CNT_W, 16: width of the error counter.

Ports:
- CLK  in  1  single clock; all state is updated on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- FLUSH  in  1  synchronous; empties the buffer.
- IN_VALID  in  1  upstream has an instruction.
- IN_READY  out  1  block can accept; driven from registered state only.
- INSTR  in  32  instruction word.
- IMM_SRC  in  3  format select. 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (zimm), 110 SH (shamt), 111 illegal.
- OUT_VALID  out  1  head entry valid.
- OUT_READY  in  1  downstream consumes the head.
- IMM_EXT  out  XLEN  immediate of the head entry.
- IMM_ERR  out  1  head entry had an illegal or unsupported format.
- ERR_CNT  out  ERR_CNT_W  count of accepted entries with an error; saturates.

## Operation
Format extraction. All signed formats sign-extend from INSTR[31] to XLEN.
- I: INSTR[31:20]
- S: {INSTR[31:25], INSTR[11:7]}
- B: {INSTR[31], INSTR[7], INSTR[30:25], INSTR[11:8], 0}
- J: {INSTR[31], INSTR[19:12], INSTR[20], INSTR[30:21], 0}
- U: {INSTR[31:12], 12'b0}, sign-extended for XLEN=64.
- Z: zero-extend INSTR[19:15].
- SH: zero-extend INSTR[25:20] when XLEN=64, INSTR[24:20] when XLEN=32. With XLEN=32 and INSTR[25]=1, IMM_ERR is set.
- Illegal (IMM_SRC=111, or no opcode match in auto mode): IMM_EXT=0, IMM_ERR=1.

Auto-decode mapping (AUTO_DECODE=1):
- 0010011 with funct3 001/101 maps to SH; other funct3 values map to I.
- 0000011 and 1100111 map to I.
- 0100011 maps to S; 1100011 maps to B; 1101111 maps to J.
- 0110111 and 0010111 map to U.
- 1110011 with funct3[2]=1 maps to Z; otherwise I.
- 0011011 (RV64 only) maps as 0010011. When XLEN=32 it is illegal.
- Anything else is illegal.

Buffer:
- 2-entry FIFO; each entry holds {IMM_EXT, IMM_ERR}. Extension is computed combinationally at the input and stored already extended.
- count ∈ {0,1,2}. OUT_VALID = (count≠0). IN_READY = (count≠2) && !RESET.
- push = IN_VALID && IN_READY. pop = OUT_VALID && OUT_READY.
- count changes by push − pop. FIFO order is preserved.
- Push and pop in the same cycle at count=1: the head becomes the new entry and count stays 1.
- A pop at count=0 is impossible by construction. A push at count=2 is prevented by IN_READY=0.
- OUT_VALID/IMM_EXT/IMM_ERR are held stable while OUT_VALID && !OUT_READY.

Error counter:
- Increments by 1 on each push whose computed IMM_ERR=1.
- Saturates at 2^ERR_CNT_W − 1.
- Not cleared by FLUSH.

## Timing
- Reset values: count=0, OUT_VALID=0, IMM_EXT=0, IMM_ERR=0, ERR_CNT=0. IN_READY=0 while RESET is high and 1 in the first cycle after.
- Latency: an instruction pushed in cycle N appears at the head in cycle N+1 when the buffer was empty. Throughput is 1 per cycle while OUT_READY=1.
- Stall absorption: with OUT_READY low, two pushes are accepted. IN_READY drops in the cycle after the second push and returns in the cycle after the first pop.
- FLUSH: next-cycle count=0 and OUT_VALID=0. A push offered in the FLUSH cycle is discarded and does not update ERR_CNT. IN_READY is unaffected by FLUSH in that cycle.
- RESET has priority over FLUSH. Reset mid-stream drops all entries and clears ERR_CNT.
- The stored IMM_EXT is 0 whenever the entry is empty.

## Test plan
- XLEN=32, IMM_SRC=000, INSTR=32'hFFF00093, OUT_READY=1 -> next cycle OUT_VALID=1, IMM_EXT=32'hFFFFFFFF, IMM_ERR=0.
- IMM_SRC=010, INSTR=32'hFE000EE3 -> IMM_EXT=32'hFFFFFFFC. IMM_SRC=100, INSTR=32'h12345037 -> 32'h12345000.
- XLEN=64, AUTO_DECODE=1, INSTR=32'h800000B7 -> IMM_EXT=64'hFFFFFFFF80000000. INSTR=32'h03F09093 (slli, shamt 63) -> 64'd63, IMM_ERR=0.
- OUT_READY=0, three back-to-back pushes (I, S, B) -> first two accepted, IN_READY=0 on the third. Raising OUT_READY drains in order I, S, B with no loss or duplication.
- IMM_SRC=111 pushed 3 times -> IMM_ERR=1, IMM_EXT=0, ERR_CNT=3. With ERR_CNT_W=2, 5 errors give ERR_CNT=3 (saturated).
- Two entries held, FLUSH=1 together with IN_VALID=1 -> next cycle OUT_VALID=0 and count=0, the offered entry is dropped, and ERR_CNT is unchanged. RESET asserted mid-stream -> all outputs return to their reset values.
